// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-port bundle: ALU writeback, load return, decode read
// addresses, and the registered write port toward the register file.
interface rf_wr_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          alu_wr_req;
  logic [AW-1:0] alu_wr_addr;
  logic [DW-1:0] alu_wr_data;
  logic          alu_grant;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic [AW-1:0] rd_addrA;
  logic [AW-1:0] rd_addrB;
  logic          rd_hazard;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;

  modport master (
    output alu_wr_req, alu_wr_addr, alu_wr_data, ld_valid, ld_data, rd_addrA, rd_addrB,
    input  alu_grant, ld_ready, rd_hazard, rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    input  alu_wr_req, alu_wr_addr, alu_wr_data, ld_valid, ld_data, rd_addrA, rd_addrB,
    output alu_grant, ld_ready, rd_hazard, rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback and a
// small load-return FIFO, with starvation-driven drain and a decode hazard flag.
module rf_wr_arbiter #(
  parameter int DW         = 8,
  parameter int AW         = 3,
  parameter int QDEPTH     = 2,
  parameter int DED_REG    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  rf_wr_arbiter_if.slave  bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(QDEPTH);
  localparam logic [CW-1:0] ZERO_CNT   = {CW{1'b0}};
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [AW-1:0] DED_ADDR   = AW'(DED_REG);

  typedef enum logic {ST_NORMAL = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t        state_r, state_n_s;
  logic [CW-1:0] count_r, count_n_s;
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [SW-1:0] starve_r, starve_n_s;
  logic [DW-1:0] fifo_r [QDEPTH];
  logic          rf_wr_en_r;
  logic [AW-1:0] rf_wr_addr_r;
  logic [DW-1:0] rf_wr_data_r;
  logic          ld_ready_s, not_empty_s, push_s, pop_s, alu_win_s;

  assign ld_ready_s  = (count_r != FULL_CNT);
  assign not_empty_s = (count_r != ZERO_CNT);
  assign push_s      = bus.ld_valid && ld_ready_s;

  // Grant decision; nothing wins while reset is asserted
  always_comb begin
    alu_win_s = 1'b0;
    pop_s     = 1'b0;
    if (!rst_n) begin
      alu_win_s = 1'b0;
      pop_s     = 1'b0;
    end else if (state_r == ST_DRAIN) begin
      alu_win_s = bus.alu_wr_req && !not_empty_s;
      pop_s     = not_empty_s;
    end else begin
      alu_win_s = bus.alu_wr_req;
      pop_s     = !bus.alu_wr_req && not_empty_s;
    end
  end

  // Next occupancy, starvation count and mode; DRAIN is chosen from the post-update values
  always_comb begin
    count_n_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_n_s = count_r + CW'(1);
      2'b01:   count_n_s = count_r - CW'(1);
      default: count_n_s = count_r;
    endcase
    starve_n_s = starve_r;
    if (pop_s) begin
      starve_n_s = {SW{1'b0}};
    end else if (not_empty_s && alu_win_s && (starve_r != STARVE_LIM)) begin
      starve_n_s = starve_r + SW'(1);
    end else begin
      starve_n_s = starve_r;
    end
    state_n_s = state_r;
    case (state_r)
      ST_NORMAL: begin
        if ((count_n_s == FULL_CNT) || ((starve_n_s == STARVE_LIM) && (count_n_s != ZERO_CNT))) begin
          state_n_s = ST_DRAIN;
        end else begin
          state_n_s = ST_NORMAL;
        end
      end
      ST_DRAIN: begin
        if (count_n_s == ZERO_CNT) begin
          state_n_s = ST_NORMAL;
        end else begin
          state_n_s = ST_DRAIN;
        end
      end
      default: state_n_s = ST_NORMAL;
    endcase
  end

  // Mode, occupancy, starvation and pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_NORMAL;
      count_r  <= ZERO_CNT;
      starve_r <= {SW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
    end else begin
      state_r  <= state_n_s;
      count_r  <= count_n_s;
      starve_r <= ((state_r == ST_NORMAL) && (state_n_s == ST_DRAIN)) ? {SW{1'b0}} : starve_n_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

  // Load-return storage; contents need no reset since occupancy gates them
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= bus.ld_data;
    end
  end

  // Registered register-file write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wr_en_r   <= 1'b0;
      rf_wr_addr_r <= {AW{1'b0}};
      rf_wr_data_r <= {DW{1'b0}};
    end else if (alu_win_s) begin
      rf_wr_en_r   <= 1'b1;
      rf_wr_addr_r <= bus.alu_wr_addr;
      rf_wr_data_r <= bus.alu_wr_data;
    end else if (pop_s) begin
      rf_wr_en_r   <= 1'b1;
      rf_wr_addr_r <= DED_ADDR;
      rf_wr_data_r <= fifo_r[rd_ptr_r];
    end else begin
      rf_wr_en_r   <= 1'b0;
    end
  end

  assign bus.alu_grant  = alu_win_s;
  assign bus.ld_ready   = ld_ready_s;
  assign bus.rf_wr_en   = rf_wr_en_r;
  assign bus.rf_wr_addr = rf_wr_addr_r;
  assign bus.rf_wr_data = rf_wr_data_r;
  assign bus.rd_hazard  = ((bus.rd_addrA == DED_ADDR) || (bus.rd_addrB == DED_ADDR)) &&
                          (not_empty_s || bus.ld_valid || (rf_wr_en_r && (rf_wr_addr_r == DED_ADDR)));
endmodule
